// File: rtl/mux_sched_pkg.sv
// Shared constants, state encoding and round-robin helpers for the mux16 scheduler.
package mux_sched_pkg;

    localparam int NCH       = 16;
    localparam int SELW      = 4;
    localparam int TIMEOUT_W = 16;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_e;

    function automatic logic [NCH-1:0] onehot(input logic [SELW-1:0] sel);
        return NCH'(1) << sel;
    endfunction

    // First set request after 'base', wrapping; base itself has the lowest priority.
    function automatic logic [SELW-1:0] rr_pick(input logic [NCH-1:0]  r,
                                                input logic [SELW-1:0] base);
        logic [SELW-1:0] w;
        logic [SELW-1:0] idx;
        w = base;
        for (int i = NCH; i >= 1; i--) begin
            idx = base + SELW'(i);
            if (r[idx]) begin
                w = idx;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/mux16_bus.sv
// DW-wide 16:1 data mux driven by the scheduler's registered select.
module mux16_bus
    import mux_sched_pkg::*;
#(
    parameter int DW = 1
) (
    input  logic [NCH*DW-1:0] data_i,
    input  logic [SELW-1:0]   sel_i,
    output logic [DW-1:0]     data_o
);

    assign data_o = data_i[sel_i*DW +: DW];

endmodule

// File: rtl/mux16_rr_scheduler.sv
// Round-robin scheduler sharing one 16:1 mux output between 16 valid/ready requesters.
// Optional stall timeout abort enabled by defining MUX_SCHED_TIMEOUT_EN.
//   state  | meaning
//   S_IDLE | no word presented; arbitrate when en & |req
//   S_SEND | granted word presented on out_data, waiting for out_ready
module mux16_rr_scheduler
    import mux_sched_pkg::*;
#(
    parameter int DW      = 1,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [NCH-1:0]    req,
    input  logic [NCH*DW-1:0] data_in,
    output logic [DW-1:0]     out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [SELW-1:0]   out_sel,
    output logic [NCH-1:0]    ack,
    output logic              busy,
    output logic              timeout_err
);

    if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
        $error("mux16_rr_scheduler: TIMEOUT out of range 1..65535");
    end

    state_e          state_q, state_d;
    logic [SELW-1:0] sel_q,   sel_d;
    logic [SELW-1:0] last_q,  last_d;
    logic [NCH-1:0]  ack_q,   ack_d;
    logic            terr_q,  terr_d;
    logic [NCH-1:0]  req_others;
    logic [DW-1:0]   mux_data;

`ifdef MUX_SCHED_TIMEOUT_EN
    localparam logic [TIMEOUT_W-1:0] STALL_LAST = TIMEOUT_W'(TIMEOUT - 1);
    logic [TIMEOUT_W-1:0] stall_q, stall_d;
`endif

    // Requests competing for a back-to-back grant: the channel being served is excluded.
    assign req_others = req & ~onehot(sel_q);

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        last_d  = last_q;
        ack_d   = '0;
        terr_d  = 1'b0;
`ifdef MUX_SCHED_TIMEOUT_EN
        stall_d = stall_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (en && |req) begin
                    sel_d   = rr_pick(req, last_q);
                    state_d = S_SEND;
`ifdef MUX_SCHED_TIMEOUT_EN
                    stall_d = '0;
`endif
                end
            end
            S_SEND: begin
                if (out_ready) begin
                    ack_d  = onehot(sel_q);
                    last_d = sel_q;
                    if (en && |req_others) begin
                        sel_d = rr_pick(req_others, sel_q);
`ifdef MUX_SCHED_TIMEOUT_EN
                        stall_d = '0;
`endif
                    end else begin
                        state_d = S_IDLE;
                    end
                end
`ifdef MUX_SCHED_TIMEOUT_EN
                else if (stall_q == STALL_LAST) begin
                    // Abort: the stalled channel counts as served so the next grant moves on.
                    state_d = S_IDLE;
                    last_d  = sel_q;
                    terr_d  = 1'b1;
                end else begin
                    stall_d = stall_q + 1'b1;
                end
`endif
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            sel_q   <= '0;
            last_q  <= SELW'(NCH - 1);
            ack_q   <= '0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            ack_q   <= ack_d;
            terr_q  <= terr_d;
        end
    end

`ifdef MUX_SCHED_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end
    assign timeout_err = terr_q;
`else
    assign timeout_err = 1'b0;
`endif

    mux16_bus #(
        .DW (DW)
    ) u_bus (
        .data_i (data_in),
        .sel_i  (sel_q),
        .data_o (mux_data)
    );

    assign out_valid = (state_q == S_SEND);
    assign busy      = (state_q == S_SEND);
    assign out_sel   = sel_q;
    assign ack       = ack_q;
    assign out_data  = out_valid ? mux_data : '0;

endmodule

// File: tb/tb_mux16_rr_scheduler.sv
// Self-checking bench for mux16_rr_scheduler: vector table plus accept scoreboard.
module tb_mux16_rr_scheduler;

    localparam int DW = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              en = 1'b0;
    logic              out_ready = 1'b0;
    logic [15:0]       req = '0;
    logic [16*DW-1:0]  data_in;
    logic [DW-1:0]     out_data;
    logic              out_valid;
    logic [3:0]        out_sel;
    logic [15:0]       ack;
    logic              busy;
    logic              timeout_err;

    mux16_rr_scheduler #(
        .DW      (DW),
        .TIMEOUT (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .req         (req),
        .data_in     (data_in),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_sel     (out_sel),
        .ack         (ack),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]    sel;
        logic [DW-1:0] data;
    } beat_t;

    typedef struct {
        logic [15:0] req;
        logic [3:0]  sel;
    } vec_t;

    beat_t       sb_q[$];
    beat_t       mon_e;
    logic [15:0] exp_ack = '0;
    int          n_checks = 0;
    int          n_fail = 0;
    vec_t        vecs[12];
    int          lat;

    function automatic logic [DW-1:0] chan_data(input int i);
        return DW'(i * 37 + 5);
    endfunction

    task automatic check(input string nm, input int unsigned act, input int unsigned exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic push(input int sel);
        beat_t b;
        b.sel  = 4'(sel);
        b.data = chan_data(sel);
        sb_q.push_back(b);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        en = 1'b0;
        out_ready = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, out_valid, 0);
        check({tag, "_sel"}, out_sel, 0);
        check({tag, "_ack"}, ack, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_terr"}, timeout_err, 0);
        check({tag, "_data"}, out_data, 0);
    endtask

    // Accept monitor: every accepted beat is compared with the scoreboard head,
    // and the ack pulse one cycle later must name that channel only.
    always @(negedge clk) begin
        if (rst) begin
            exp_ack = '0;
        end else begin
            check("ack", ack, exp_ack);
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_accept: got sel %0d, expected no accept", out_sel);
                    exp_ack = '0;
                end else begin
                    mon_e = sb_q.pop_front();
                    check("accept_sel", out_sel, mon_e.sel);
                    check("accept_data", out_data, mon_e.data);
                    exp_ack = 16'(1) << mon_e.sel;
                end
            end else begin
                exp_ack = '0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 16; i++) data_in[i*DW +: DW] = chan_data(i);

        // last starts at 15 after reset
        vecs[0]  = '{16'h8001, 4'd0};
        vecs[1]  = '{16'h0020, 4'd5};
        vecs[2]  = '{16'h0021, 4'd0};
        vecs[3]  = '{16'h0021, 4'd5};
        vecs[4]  = '{16'h8010, 4'd15};
        vecs[5]  = '{16'h8010, 4'd4};
        vecs[6]  = '{16'hFFFF, 4'd5};
        vecs[7]  = '{16'h0010, 4'd4};
        vecs[8]  = '{16'h0011, 4'd0};
        vecs[9]  = '{16'h8000, 4'd15};
        vecs[10] = '{16'h8001, 4'd0};
        vecs[11] = '{16'h0101, 4'd8};

        // T1: reset values, then asynchronous reset in the middle of a SEND
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("t1_rst");
        rst = 1'b0;
        req = 16'h0400;
        en = 1'b1;
        out_ready = 1'b0;
        tick();
        check("t1_pre_valid", out_valid, 1);
        check("t1_pre_sel", out_sel, 10);
        #2;
        rst = 1'b1;
        req = '0;
        #1;
        check_reset_outputs("t1_async");
        tick();
        rst = 1'b0;

        // Table: single transfers, en dropped on the accept so each ends in IDLE
        for (int v = 0; v < 12; v++) begin
            req = vecs[v].req;
            en = 1'b1;
            out_ready = 1'b0;
            push(vecs[v].sel);
            lat = 0;
            do begin
                tick();
                lat++;
            end while (!out_valid && lat < 8);
            check("vec_latency", lat, 1);
            check("vec_sel", out_sel, vecs[v].sel);
            check("vec_busy", busy, 1);
            en = 1'b0;
            out_ready = 1'b1;
            tick();
            req = '0;
            out_ready = 1'b0;
            en = 1'b1;
            check("vec_idle", out_valid, 0);
        end

        // T3: all requesting, back-to-back rotation 0..15,0
        do_reset();
        for (int k = 0; k < 17; k++) push(k % 16);
        req = 16'hFFFF;
        en = 1'b1;
        out_ready = 1'b1;
        tick();
        for (int k = 0; k < 17; k++) begin
            check("t3_valid", out_valid, 1);
            check("t3_sel", out_sel, k % 16);
            if (k == 16) en = 1'b0;
            tick();
        end
        req = '0;
        en = 1'b1;
        out_ready = 1'b0;
        check("t3_idle", out_valid, 0);

        // T4: backpressure holds the grant; release serves ch0 then ch15
        do_reset();
        push(0);
        push(15);
        req = 16'h8001;
        en = 1'b1;
        tick();
        for (int k = 0; k < 10; k++) begin
            check("t4_hold_valid", out_valid, 1);
            check("t4_hold_sel", out_sel, 0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        check("t4_ack0", ack, 16'h0001);
        check("t4_next_valid", out_valid, 1);
        check("t4_next_sel", out_sel, 15);
        en = 1'b0;
        tick();
        req = '0;
        en = 1'b1;
        out_ready = 1'b0;
        check("t4_ack15", ack, 16'h8000);
        check("t4_idle", out_valid, 0);

        // T5: en low during SEND completes the word but blocks new grants
        req = 16'hFFFF;
        push(0);
        tick();
        check("t5_sel", out_sel, 0);
        en = 1'b0;
        out_ready = 1'b1;
        tick();
        for (int k = 0; k < 5; k++) begin
            check("t5_blocked_valid", out_valid, 0);
            check("t5_blocked_data", out_data, 0);
            tick();
        end
        push(1);
        en = 1'b1;
        tick();
        check("t5_regrant_valid", out_valid, 1);
        check("t5_regrant_sel", out_sel, 1);
        en = 1'b0;
        tick();
        req = '0;
        en = 1'b1;
        out_ready = 1'b0;
        check("t5_idle", out_valid, 0);

`ifdef MUX_SCHED_TIMEOUT_EN
        // T6: four stall cycles abort ch0 without ack; the next grant skips it
        do_reset();
        req = 16'h0003;
        en = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) begin
            check("t6_stall_valid", out_valid, 1);
            check("t6_stall_terr", timeout_err, 0);
            tick();
        end
        check("t6_terr", timeout_err, 1);
        check("t6_abort_valid", out_valid, 0);
        tick();
        check("t6_terr_pulse", timeout_err, 0);
        check("t6_next_sel", out_sel, 1);
        check("t6_next_valid", out_valid, 1);
        push(1);
        en = 1'b0;
        out_ready = 1'b1;
        tick();
        req = '0;
        en = 1'b1;
        out_ready = 1'b0;
`endif

        repeat (2) tick();
        check("sb_empty", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
